arbitro_rr: RTL and testbench
=============================

ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 Parameter: BURST, default 2, max consecutive pops granted to one input before priority rotates (legal 1..4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 active  input  1  configuration enable; 0 forces IDLE.
REQ-005 fifo_empty  input  4  empty flags of the 4 input FIFOs; request[i] = !fifo_empty[i].
REQ-006 almost_full  input  4  almost-full flags of the 4 destination FIFOs; pause = OR of all bits.
REQ-007 pop  output  4  one-hot (or zero) read strobe to input FIFOs, combinational from registered state and current inputs.
REQ-008 selector  output  2  registered index of the input popped in the previous cycle; drives the datapath mux.
REQ-009 valid_out  output  1  registered; 1 when the previous cycle issued a pop.
REQ-010 state  output  2  current FSM state encoding (IDLE=0, SERVE=1, PAUSE=2).

Function
REQ-011 FSM states: IDLE, SERVE, PAUSE; encoding 3 is unreachable and SHALL recover to IDLE next cycle.
REQ-012 IDLE -> SERVE when active=1; stays IDLE otherwise.
REQ-013 SERVE -> PAUSE when pause=1; SERVE -> IDLE when active=0 (active=0 has priority over pause).
REQ-014 PAUSE -> SERVE after pause=0 for 2 consecutive cycles (hysteresis counter, cleared whenever pause=1); PAUSE -> IDLE when active=0.
REQ-015 pop nonzero only when state=SERVE, active=1, pause=0, and at least one request set.
REQ-016 Winner w = first requesting index scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); pop[w]=1, all other bits 0.
REQ-017 Pointer update on a pop to w: w==ptr and cnt<BURST-1 -> cnt+1, ptr held; w==ptr and cnt==BURST-1 -> ptr=w+1 mod 4, cnt=0.
REQ-018 w!=ptr -> ptr=w, cnt=1; if BURST==1 instead ptr=w+1 mod 4, cnt=0.
REQ-019 No pop in a cycle -> ptr and cnt held.
REQ-020 selector and valid_out SHALL lag pop by exactly 1 cycle, aligning with registered FIFO read data; selector holds its last value when valid_out=0.
REQ-021 pause asserting in a cycle SHALL suppress pop in that same cycle, regardless of state (zero-cycle backpressure).
REQ-022 pop never asserted to an input whose fifo_empty=1 in the same cycle.
REQ-023 ptr wraps 3 -> 0; cnt width 2 bits, never exceeds BURST-1.

Reset
REQ-024 While reset=1 at a clock edge: state=IDLE, ptr=0, cnt=0, hysteresis counter=0, selector=0, valid_out=0.
REQ-025 During and in the cycle after reset, pop SHALL be 0 (state IDLE).
REQ-026 Reset mid-operation SHALL abort immediately: no pop in the reset cycle's following cycle, valid_out=0 next cycle, arbitration restarts from ptr=0.
REQ-027 reset has priority over active, pause and all requests.

Verification
REQ-028 Reset, active=1, fifo_empty=4'b0000, almost_full=0, BURST=2 -> after IDLE->SERVE, pop sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; selector/valid_out follow 1 cycle later.
REQ-029 SERVE, fifo_empty=4'b1010 (inputs 0,2 requesting), BURST=1 -> pop alternates 0001,0100,0001; inputs 1,3 never popped.
REQ-030 SERVE with requests, almost_full=4'b0100 for 1 cycle -> pop=0 that same cycle, state=PAUSE next; pause=0 two cycles -> SERVE on the third cycle, pops resume from held ptr/cnt.
REQ-031 active dropped to 0 while SERVE and pause=1 in same cycle -> pop=0, next state IDLE (not PAUSE); valid_out=0 on following cycle.
REQ-032 reset asserted 1 cycle while popping input 2 with cnt=1 -> pop=0 next cycle, valid_out=0, selector=0; after release first pop goes to lowest requesting index from ptr=0.
REQ-033 All fifo_empty=1 in SERVE -> pop=0, valid_out=0 next cycle, ptr/cnt unchanged, selector holds previous value.

Source files
------------

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - Round-robin pop arbiter for four input FIFOs with burst and backpressure
module arbitro_rr #(
  parameter int BURST = 2  // consecutive pops granted to one input before rotating, 1..4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic [3:0] fifo_empty,
  input  logic [3:0] almost_full,
  output logic [3:0] pop,
  output logic [1:0] selector,
  output logic       valid_out,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] BURST_LAST = 2'(BURST - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] hyst_q, hyst_d;
  logic [1:0] selector_q, selector_d;
  logic       valid_q, valid_d;

  logic [3:0] request;
  logic       pause;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       grant_en;

  assign request = ~fifo_empty;
  assign pause   = |almost_full;

  // Winner search: first requesting input starting at ptr and wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + i[1:0];
      if (!win_found && request[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pop is gated by reset and by pause in the same cycle, so backpressure costs zero cycles.
  always_comb begin
    grant_en = !reset && (state_q == SERVE) && active && !pause && win_found;
    pop      = grant_en ? (4'b0001 << win_idx) : 4'b0000;
  end

  // Burst pointer update: stay on the same input for BURST pops, then move past it.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (grant_en) begin
      if (win_idx == ptr_q) begin
        if (cnt_q == BURST_LAST) begin
          ptr_d = ptr_q + 2'd1;
          cnt_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end else if (BURST == 1) begin
        ptr_d = win_idx + 2'd1;
        cnt_d = 2'd0;
      end else begin
        ptr_d = win_idx;
        cnt_d = 2'd1;
      end
    end
  end

  // Next-state logic; losing active wins over pause, and PAUSE needs two quiet cycles to exit.
  always_comb begin
    state_d = state_q;
    hyst_d  = 2'd0;
    case (state_q)
      IDLE: begin
        if (active) state_d = SERVE;
      end
      SERVE: begin
        if (!active)    state_d = IDLE;
        else if (pause) state_d = PAUSE;
      end
      PAUSE: begin
        if (!active) begin
          state_d = IDLE;
        end else if (pause) begin
          hyst_d = 2'd0;
        end else if (hyst_q == 2'd1) begin
          state_d = SERVE;
        end else begin
          hyst_d = hyst_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath mux control lags pop by one cycle to line up with registered FIFO read data.
  always_comb begin
    selector_d = grant_en ? win_idx : selector_q;
    valid_d    = grant_en;
  end

  // State register with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      cnt_q      <= 2'd0;
      hyst_q     <= 2'd0;
      selector_q <= 2'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      hyst_q     <= hyst_d;
      selector_q <= selector_d;
      valid_q    <= valid_d;
    end
  end

  assign selector  = selector_q;
  assign valid_out = valid_q;
  assign state     = state_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// tb/tb_arbitro_rr.sv - Self-checking bench for arbitro_rr with BURST=2 and BURST=1 instances
module tb_arbitro_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic       active;
  logic [3:0] fifo_empty;
  logic [3:0] almost_full;
  logic [3:0] pop_a, pop_b;
  logic [1:0] sel_a, sel_b, st_a, st_b;
  logic       vo_a, vo_b;

  always #5 clk = ~clk;

  arbitro_rr #(.BURST(2)) dut_a (
    .clk(clk), .reset(reset), .active(active), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .pop(pop_a), .selector(sel_a),
    .valid_out(vo_a), .state(st_a)
  );

  arbitro_rr #(.BURST(1)) dut_b (
    .clk(clk), .reset(reset), .active(active), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .pop(pop_b), .selector(sel_b),
    .valid_out(vo_b), .state(st_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 follows dut_a (BURST=2), index 1 follows dut_b (BURST=1).
  int burst [2] = '{2, 1};
  int m_state [2] = '{0, 0};
  int m_ptr   [2] = '{0, 0};
  int m_cnt   [2] = '{0, 0};
  int m_quiet [2] = '{0, 0};
  int m_sel   [2] = '{0, 0};
  int m_valid [2] = '{0, 0};

  function automatic int winner(int k);
    int idx;
    if (reset || m_state[k] != 1 || !active || almost_full != 4'b0000) return -1;
    for (int i = 0; i < 4; i++) begin
      idx = (m_ptr[k] + i) % 4;
      if (!fifo_empty[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_pop(int k);
    int w;
    w = winner(k);
    if (w < 0) return 4'b0000;
    return 4'b0001 << w;
  endfunction

  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      int w;
      int ns;
      w = winner(k);
      if (reset) begin
        m_state[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
        m_quiet[k] = 0; m_sel[k] = 0; m_valid[k] = 0;
      end else begin
        m_valid[k] = (w >= 0);
        if (w >= 0) begin
          m_sel[k] = w;
          if (w == m_ptr[k]) begin
            if (m_cnt[k] + 1 < burst[k]) m_cnt[k] = m_cnt[k] + 1;
            else begin m_ptr[k] = (m_ptr[k] + 1) % 4; m_cnt[k] = 0; end
          end else if (burst[k] == 1) begin
            m_ptr[k] = (w + 1) % 4; m_cnt[k] = 0;
          end else begin
            m_ptr[k] = w; m_cnt[k] = 1;
          end
        end
        ns = m_state[k];
        case (m_state[k])
          0: if (active) ns = 1;
          1: if (!active) ns = 0; else if (almost_full != 0) ns = 2;
          2: begin
            if (!active) ns = 0;
            else if (almost_full != 0) m_quiet[k] = 0;
            else begin
              m_quiet[k] = m_quiet[k] + 1;
              if (m_quiet[k] >= 2) ns = 1;
            end
          end
          default: ns = 0;
        endcase
        if (ns != 2) m_quiet[k] = 0;
        m_state[k] = ns;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic drive(input logic r, input logic a, input logic [3:0] fe, input logic [3:0] af);
    reset = r; active = a; fifo_empty = fe; almost_full = af;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 4'b0000, 4'b0000);
    tick(); tick();
    drive(1'b1, 1'b1, 4'b0000, 4'b0000);
    checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state_a got=%0d exp=0", st_a); end
    checks++; if (st_b !== 2'd0) begin errors++; $display("FAIL reset_state_b got=%0d exp=0", st_b); end
    checks++; if (pop_a !== 4'b0000) begin errors++; $display("FAIL reset_pop_a got=%b exp=0000", pop_a); end
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got=%b exp=0", vo_a); end
    checks++; if (sel_a !== 2'd0) begin errors++; $display("FAIL reset_sel_a got=%0d exp=0", sel_a); end
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] tbl [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    int         idx [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    checks++; if (pop_a !== 4'b0000) begin errors++; $display("FAIL rot_idle_pop got=%b exp=0000", pop_a); end
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 4'b0000, 4'b0000);
      checks++; if (pop_a !== tbl[i]) begin errors++; $display("FAIL rot_pop[%0d] got=%b exp=%b", i, pop_a, tbl[i]); end
      checks++; if (pop_b !== exp_pop(1)) begin errors++; $display("FAIL rot_pop_b[%0d] got=%b exp=%b", i, pop_b, exp_pop(1)); end
      if (i == 0) begin
        checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL rot_valid0 got=%b exp=0", vo_a); end
      end else begin
        checks++; if (vo_a !== 1'b1) begin errors++; $display("FAIL rot_valid[%0d] got=%b exp=1", i, vo_a); end
        checks++; if (sel_a !== idx[i-1][1:0]) begin errors++; $display("FAIL rot_sel[%0d] got=%0d exp=%0d", i, sel_a, idx[i-1]); end
      end
      tick();
    end
  endtask

  task automatic test_burst1();
    logic [3:0] tbl [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    drive(1'b1, 1'b1, 4'b1010, 4'b0000);
    tick();
    drive(1'b0, 1'b1, 4'b1010, 4'b0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 4'b1010, 4'b0000);
      checks++; if (pop_b !== tbl[i]) begin errors++; $display("FAIL b1_pop[%0d] got=%b exp=%b", i, pop_b, tbl[i]); end
      checks++; if (pop_a !== exp_pop(0)) begin errors++; $display("FAIL b1_pop_a[%0d] got=%b exp=%b", i, pop_a, exp_pop(0)); end
      tick();
    end
  endtask

  task automatic test_pause();
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    checks++; if (pop_a !== exp_pop(0)) begin errors++; $display("FAIL pause_pre got=%b exp=%b", pop_a, exp_pop(0)); end
    tick();
    drive(1'b0, 1'b1, 4'b0000, 4'b0100);
    checks++; if (pop_a !== 4'b0000) begin errors++; $display("FAIL pause_same_cycle_a got=%b exp=0000", pop_a); end
    checks++; if (pop_b !== 4'b0000) begin errors++; $display("FAIL pause_same_cycle_b got=%b exp=0000", pop_b); end
    tick();
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    checks++; if (st_a !== 2'd2) begin errors++; $display("FAIL pause_state1 got=%0d exp=2", st_a); end
    checks++; if (pop_a !== 4'b0000) begin errors++; $display("FAIL pause_pop1 got=%b exp=0000", pop_a); end
    tick();
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    checks++; if (st_b !== 2'd2) begin errors++; $display("FAIL pause_state2 got=%0d exp=2", st_b); end
    tick();
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    checks++; if (st_a !== 2'd1) begin errors++; $display("FAIL pause_resume_state got=%0d exp=1", st_a); end
    checks++; if (pop_a !== exp_pop(0) || pop_a === 4'b0000) begin errors++; $display("FAIL pause_resume_pop_a got=%b exp=%b", pop_a, exp_pop(0)); end
    checks++; if (pop_b !== exp_pop(1)) begin errors++; $display("FAIL pause_resume_pop_b got=%b exp=%b", pop_b, exp_pop(1)); end
    tick();
  endtask

  task automatic test_active_drop();
    drive(1'b0, 1'b0, 4'b0000, 4'b0001);
    checks++; if (pop_a !== 4'b0000) begin errors++; $display("FAIL drop_pop got=%b exp=0000", pop_a); end
    tick();
    drive(1'b0, 1'b0, 4'b0000, 4'b0000);
    checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL drop_state_a got=%0d exp=0", st_a); end
    checks++; if (st_b !== 2'd0) begin errors++; $display("FAIL drop_state_b got=%0d exp=0", st_b); end
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL drop_valid got=%b exp=0", vo_a); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    drive(1'b1, 1'b1, 4'b0000, 4'b0000);
    tick();
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    tick();
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 1'b1, 4'b0000, 4'b0000);
      if (m_state[0] == 1 && m_ptr[0] == 2 && m_cnt[0] == 1) found = 1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_reach got=0 exp=1"); end
    checks++; if (pop_a !== 4'b0100) begin errors++; $display("FAIL rmid_popping2 got=%b exp=0100", pop_a); end
    drive(1'b1, 1'b1, 4'b0000, 4'b0000);
    checks++; if (pop_a !== 4'b0000) begin errors++; $display("FAIL rmid_reset_cycle_pop got=%b exp=0000", pop_a); end
    tick();
    drive(1'b0, 1'b1, 4'b1001, 4'b0000);
    checks++; if (pop_a !== 4'b0000) begin errors++; $display("FAIL rmid_after_pop got=%b exp=0000", pop_a); end
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", vo_a); end
    checks++; if (sel_a !== 2'd0) begin errors++; $display("FAIL rmid_sel got=%0d exp=0", sel_a); end
    tick();
    drive(1'b0, 1'b1, 4'b1001, 4'b0000);
    checks++; if (pop_a !== 4'b0010) begin errors++; $display("FAIL rmid_first_a got=%b exp=0010", pop_a); end
    checks++; if (pop_b !== 4'b0010) begin errors++; $display("FAIL rmid_first_b got=%b exp=0010", pop_b); end
    tick();
  endtask

  task automatic test_all_empty();
    int held_sel;
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    tick();
    held_sel = m_sel[0];
    drive(1'b0, 1'b1, 4'b1111, 4'b0000);
    checks++; if (pop_a !== 4'b0000) begin errors++; $display("FAIL empty_pop got=%b exp=0000", pop_a); end
    tick();
    drive(1'b0, 1'b1, 4'b1111, 4'b0000);
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL empty_valid got=%b exp=0", vo_a); end
    checks++; if (sel_a !== held_sel[1:0]) begin errors++; $display("FAIL empty_sel_hold got=%0d exp=%0d", sel_a, held_sel); end
    tick();
    drive(1'b0, 1'b1, 4'b0000, 4'b0000);
    checks++; if (pop_a !== exp_pop(0)) begin errors++; $display("FAIL empty_resume_a got=%b exp=%b", pop_a, exp_pop(0)); end
    checks++; if (pop_b !== exp_pop(1)) begin errors++; $display("FAIL empty_resume_b got=%b exp=%b", pop_b, exp_pop(1)); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic       r, a;
      logic [3:0] fe, af;
      r  = ($urandom_range(0, 39) == 0);
      a  = ($urandom_range(0, 9) != 0);
      fe = 4'($urandom);
      af = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      drive(r, a, fe, af);
      for (int k = 0; k < 2; k++) begin
        logic [3:0] ap;
        logic [1:0] as_, ast;
        logic       av;
        ap  = k ? pop_b : pop_a;
        as_ = k ? sel_b : sel_a;
        ast = k ? st_b : st_a;
        av  = k ? vo_b : vo_a;
        checks++; if (ap !== exp_pop(k)) begin errors++; $display("FAIL rnd_pop[%0d] k=%0d got=%b exp=%b", n, k, ap, exp_pop(k)); end
        checks++; if (as_ !== m_sel[k][1:0]) begin errors++; $display("FAIL rnd_sel[%0d] k=%0d got=%0d exp=%0d", n, k, as_, m_sel[k]); end
        checks++; if (av !== m_valid[k][0]) begin errors++; $display("FAIL rnd_valid[%0d] k=%0d got=%b exp=%0d", n, k, av, m_valid[k]); end
        checks++; if (ast !== m_state[k][1:0]) begin errors++; $display("FAIL rnd_state[%0d] k=%0d got=%0d exp=%0d", n, k, ast, m_state[k]); end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; active = 1'b0; fifo_empty = 4'b1111; almost_full = 4'b0000;
    #1;
    test_reset();
    test_rotation();
    test_burst1();
    test_pause();
    test_active_drop();
    test_reset_mid();
    test_all_empty();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
